// File: rtl/lfsr_pkg.sv
// Shared constants and the next-state function for the 16-bit Fibonacci LFSR
// (polynomial x^16+x^14+x^13+x^11+1, maximal length 65535).
package lfsr_pkg;

   localparam int          LFSR16_W    = 16;
   localparam logic [15:0] LFSR16_SEED = 16'h1001;
   localparam logic [15:0] LFSR16_TAPS = 16'hB400;

   // One Fibonacci step: shift toward the MSB, XOR of tapped bits enters bit 0.
   function automatic logic [LFSR16_W-1:0] lfsr16_next(
      input logic [LFSR16_W-1:0] state,
      input logic [LFSR16_W-1:0] taps
   );
      return {state[LFSR16_W-2:0], ^(state & taps)};
   endfunction

endpackage

// File: rtl/lfsr_16_if.sv
// Bundle between the LFSR and its consumer: the consumer drives the step
// request, the LFSR returns its current state.
interface lfsr_16_if;
   import lfsr_pkg::*;

   logic                enable;
   logic [LFSR16_W-1:0] lfsr;

   modport master (output enable, input lfsr);
   modport slave  (input enable, output lfsr);

endinterface

// File: rtl/lfsr_16.sv
// 16-bit Fibonacci LFSR pattern source. Steps once per enabled clock, reloads
// SEED on synchronous reset, and escapes the all-zero lock-up state by loading
// SEED. The output comes straight from the state flops.
module lfsr_16
   import lfsr_pkg::*;
#(
   parameter int                  WIDTH = LFSR16_W,
   parameter logic [LFSR16_W-1:0] SEED  = LFSR16_SEED,
   parameter logic [LFSR16_W-1:0] TAPS  = LFSR16_TAPS
)(
   input  logic        clk,
   input  logic        reset,
   lfsr_16_if.slave    bus
);

   localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

   logic [WIDTH-1:0] state_r;
   logic [WIDTH-1:0] next_s;

   // Next-state selection: zero state is replaced by SEED instead of shifting.
   always_comb begin
      next_s = state_r;
      if (state_r == ZERO) begin
         next_s = SEED;
      end else begin
         next_s = lfsr16_next(state_r, TAPS);
      end
   end

   // State register: reset has priority over enable, otherwise hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= SEED;
      end else if (bus.enable) begin
         state_r <= next_s;
      end else begin
         state_r <= state_r;
      end
   end

   assign bus.lfsr = state_r;

endmodule

// File: tb/tb_lfsr_16.sv
// Self-checking bench for lfsr_16: directed vector table, randomized run
// against an arithmetic reference model, full-period scan and lock-up check.
module tb_lfsr_16;
   import lfsr_pkg::*;

   logic clk;
   logic reset;

   lfsr_16_if dut_bus ();
   lfsr_16_if zero_bus ();

   lfsr_16 u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (dut_bus.slave)
   );

   lfsr_16 #(.SEED(16'h0000)) u_zero (
      .clk   (clk),
      .reset (reset),
      .bus   (zero_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic        rst;
      logic        en;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [0:31];
   bit   seen [0:65535];

   // Reference: next state from the polynomial, by integer arithmetic.
   function automatic logic [15:0] ref_next(input logic [15:0] s);
      int v;
      int par;
      v   = int'(s);
      par = ((v >> 15) & 1) + ((v >> 13) & 1) + ((v >> 12) & 1) + ((v >> 10) & 1);
      if (v == 0) return 16'h1001;
      return 16'(((v * 2) % 65536) + (par % 2));
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] model;
      int          bad;
      tests_run    = 0;
      tests_failed = 0;
      reset            = 1'b1;
      dut_bus.enable   = 1'b0;
      zero_bus.enable  = 1'b0;

      // Directed table: reset, hold, 10 steps, hold, reset mid-run.
      vecs[0]  = '{1'b1, 1'b0, 16'h1001};
      vecs[1]  = '{1'b1, 1'b1, 16'h1001};
      vecs[2]  = '{1'b0, 1'b0, 16'h1001};
      vecs[3]  = '{1'b0, 1'b0, 16'h1001};
      vecs[4]  = '{1'b0, 1'b0, 16'h1001};
      vecs[5]  = '{1'b0, 1'b1, 16'h2003};
      vecs[6]  = '{1'b0, 1'b1, 16'h4007};
      vecs[7]  = '{1'b0, 1'b1, 16'h800E};
      vecs[8]  = '{1'b0, 1'b1, 16'h001D};
      vecs[9]  = '{1'b0, 1'b1, 16'h003A};
      vecs[10] = '{1'b0, 1'b1, 16'h0074};
      vecs[11] = '{1'b0, 1'b1, 16'h00E8};
      vecs[12] = '{1'b0, 1'b1, 16'h01D0};
      vecs[13] = '{1'b0, 1'b1, 16'h03A0};
      vecs[14] = '{1'b0, 1'b1, 16'h0740};
      vecs[15] = '{1'b0, 1'b0, 16'h0740};
      vecs[16] = '{1'b0, 1'b0, 16'h0740};
      vecs[17] = '{1'b1, 1'b0, 16'h1001};
      vecs[18] = '{1'b0, 1'b1, 16'h2003};
      vecs[19] = '{1'b0, 1'b1, 16'h4007};
      vecs[20] = '{1'b0, 1'b1, 16'h800E};
      vecs[21] = '{1'b0, 1'b1, 16'h001D};
      vecs[22] = '{1'b0, 1'b1, 16'h003A};
      vecs[23] = '{1'b1, 1'b1, 16'h1001};
      vecs[24] = '{1'b0, 1'b1, 16'h2003};
      vecs[25] = '{1'b0, 1'b0, 16'h2003};
      vecs[26] = '{1'b0, 1'b1, 16'h4007};
      vecs[27] = '{1'b0, 1'b0, 16'h4007};
      vecs[28] = '{1'b1, 1'b1, 16'h1001};
      vecs[29] = '{1'b1, 1'b1, 16'h1001};
      vecs[30] = '{1'b0, 1'b1, 16'h2003};
      vecs[31] = '{1'b0, 1'b1, 16'h4007};

      for (int i = 0; i < 32; i++) begin
         reset          = vecs[i].rst;
         dut_bus.enable = vecs[i].en;
         tick();
         check($sformatf("vec%0d", i), dut_bus.lfsr, vecs[i].exp);
      end

      // Randomized reset/enable run against the reference model.
      reset          = 1'b1;
      dut_bus.enable = 1'b0;
      tick();
      model = 16'h1001;
      check("rand_reset", dut_bus.lfsr, model);
      for (int i = 0; i < 300; i++) begin
         reset          = ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0;
         dut_bus.enable = $urandom_range(0, 1) == 1 ? 1'b1 : 1'b0;
         tick();
         if (reset)               model = 16'h1001;
         else if (dut_bus.enable) model = ref_next(model);
         check($sformatf("rand%0d", i), dut_bus.lfsr, model);
      end

      // Full period: every intermediate state non-zero and unique.
      reset          = 1'b1;
      dut_bus.enable = 1'b0;
      tick();
      reset          = 1'b0;
      dut_bus.enable = 1'b1;
      for (int i = 0; i < 65536; i++) seen[i] = 1'b0;
      seen[16'h1001] = 1'b1;
      model = 16'h1001;
      bad   = 0;
      for (int i = 1; i < 65535; i++) begin
         tick();
         model = ref_next(model);
         if (dut_bus.lfsr === 16'h0000 || dut_bus.lfsr !== model || seen[dut_bus.lfsr]) begin
            bad++;
         end else begin
            seen[dut_bus.lfsr] = 1'b1;
         end
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL period_unique: got %0d bad states, expected 0", bad);
      end
      tick();
      check("period_wrap", dut_bus.lfsr, 16'h1001);

      // Lock-up guard with a zero seed: reload keeps the register at zero.
      reset           = 1'b1;
      zero_bus.enable = 1'b0;
      tick();
      check("zero_reset", zero_bus.lfsr, 16'h0000);
      reset           = 1'b0;
      zero_bus.enable = 1'b1;
      tick();
      check("zero_guard", zero_bus.lfsr, 16'h0000);
      tick();
      check("zero_guard2", zero_bus.lfsr, 16'h0000);
      zero_bus.enable = 1'b0;
      dut_bus.enable  = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
